mips_data_memory: RTL

//  Memory responder for the single-cycle MIPS core: serves the core's instruction-fetch and data ports.
//  - Byte-addressed, big-endian; lane [0] is the MSB. Reads are combinational; writes commit on posedge clk.
//  - Once the core halts: freezes contents, then streams every byte out on a valid/ready dump port for the bench.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_data_memory_if.sv | 39 +++
 rtl/mips_mem_dump_seq.sv | 79 +++++++
 rtl/mips_data_memory.sv | 96 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS memory responder.
// Holds the dump FSM states, word geometry and the lane packer.
package mips_pkg;

   typedef enum logic [1:0] {
      RUN,
      DUMP,
      DONE
   } mem_state_e;

   localparam int WORD_BYTES = 4;

   // Lane [0] is the most significant byte.
   typedef logic [0:WORD_BYTES-1][7:0] lanes_t;

   function automatic logic [31:0] be_pack(input lanes_t lanes);
      be_pack = {lanes[0], lanes[1], lanes[2], lanes[3]};
   endfunction

endpackage

// File: rtl/mips_data_memory_if.sv
// Core-side bus and dump port of the MIPS memory responder.
// slave: memory side; master: core/bench side.
interface mips_data_memory_if
   import mips_pkg::*;
#(
   parameter int AW = 16
);
   logic [31:0]   inst_addr;
   logic [31:0]   inst;
   logic [31:0]   mem_addr;
   lanes_t        mem_data_in;
   lanes_t        mem_data_out;
   logic          mem_write_en;
   logic          halted;
   logic          dump_valid;
   logic          dump_ready;
   logic [AW-1:0] dump_addr;
   logic [7:0]    dump_data;
   logic          dump_done;
   logic          align_err;
   logic          range_err;
   logic [31:0]   write_count;

   modport slave (
      input  inst_addr, mem_addr, mem_data_in,
      input  mem_write_en, halted, dump_ready,
      output inst, mem_data_out,
      output dump_valid, dump_addr, dump_data, dump_done,
      output align_err, range_err, write_count
   );

   modport master (
      output inst_addr, mem_addr, mem_data_in,
      output mem_write_en, halted, dump_ready,
      input  inst, mem_data_out,
      input  dump_valid, dump_addr, dump_data, dump_done,
      input  align_err, range_err, write_count
   );
endinterface

// File: rtl/mips_mem_dump_seq.sv
// Post-halt dump sequencer: RUN/DUMP/DONE FSM and byte pointer.
// In: clk, rst_b, halted, dump_ready. Out: ptr, dump_valid, dump_done, state.
module mips_mem_dump_seq
   import mips_pkg::*;
#(
   parameter int AW      = 16,
   parameter bit DUMP_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          halted,
   input  logic          dump_ready,
   output logic [AW-1:0] ptr,
   output logic          dump_valid,
   output logic          dump_done,
   output mem_state_e    state
);

   mem_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      done_d  = done_q;
      unique case (state_q)
         RUN: begin
            if (halted) begin
               if (DUMP_EN) begin
                  state_d = DUMP;
                  valid_d = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DUMP: begin
            if (valid_q && dump_ready) begin
               ptr_d = ptr_q + AW'(1);
               // Last byte accepted: leave DUMP.
               if (ptr_q == '1) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= RUN;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign ptr        = ptr_q;
   assign dump_valid = valid_q;
   assign dump_done  = done_q;
   assign state      = state_q;

endmodule

// File: rtl/mips_data_memory.sv
// Byte-addressed big-endian memory serving MIPS fetch and data ports.
// Ports: clk, rst_b (async low), bus (slave): fetch, data, dump, status.
module mips_data_memory
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter bit DUMP_EN    = 1'b1
) (
   input logic                clk,
   input logic                rst_b,
   mips_data_memory_if.slave  bus
);

   localparam int AW = ADDR_WIDTH;

   // Storage is deliberately not reset; contents survive rst_b.
   logic [7:0]    mem_q [0:2**AW-1];

   mem_state_e    state;
   logic [AW-1:0] dump_ptr;
   logic          we_req;
   logic          aligned;
   logic          in_rng;
   logic          commit;
   logic          inst_in_rng;
   lanes_t        ilanes;
   logic          align_err_q, align_err_d;
   logic          range_err_q, range_err_d;
   logic [31:0]   write_count_q, write_count_d;
   logic          unused_bits;

   mips_mem_dump_seq #(
      .AW      (AW),
      .DUMP_EN (DUMP_EN)
   ) u_seq (
      .clk        (clk),
      .rst_b      (rst_b),
      .halted     (bus.halted),
      .dump_ready (bus.dump_ready),
      .ptr        (dump_ptr),
      .dump_valid (bus.dump_valid),
      .dump_done  (bus.dump_done),
      .state      (state)
   );

   for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
      logic [AW-1:0] ra;
      // Data reads wrap modulo the storage size.
      assign ra = bus.mem_addr[AW-1:0] + AW'(g);
      assign bus.mem_data_out[g] = mem_q[ra];
      assign ilanes[g] = mem_q[{bus.inst_addr[AW-1:2], 2'(g)}];
   end

   assign unused_bits = ^bus.inst_addr[1:0];
   assign inst_in_rng = (bus.inst_addr[31:AW] == '0);
   assign bus.inst    = inst_in_rng ? be_pack(ilanes) : '0;

   // Only writes the FSM would honour are judged for errors.
   assign we_req  = bus.mem_write_en && (state == RUN) && !bus.halted;
   assign aligned = (bus.mem_addr[1:0] == 2'b00);
   assign in_rng  = (bus.mem_addr[31:AW] == '0);
   assign commit  = we_req && aligned && in_rng;

   always_comb begin
      align_err_d   = align_err_q | (we_req && !aligned);
      range_err_d   = range_err_q | (we_req && !in_rng);
      write_count_d = write_count_q + {31'd0, commit};
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         align_err_q   <= 1'b0;
         range_err_q   <= 1'b0;
         write_count_q <= '0;
      end else begin
         align_err_q   <= align_err_d;
         range_err_q   <= range_err_d;
         write_count_q <= write_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            mem_q[{bus.mem_addr[AW-1:2], 2'(i)}] <= bus.mem_data_in[i];
         end
      end
   end

   assign bus.dump_addr   = dump_ptr;
   assign bus.dump_data   = mem_q[dump_ptr];
   assign bus.align_err   = align_err_q;
   assign bus.range_err   = range_err_q;
   assign bus.write_count = write_count_q;

endmodule
